// File: rtl/hamming_dev_pkg.sv
// Shared types and width helpers for the Hamming-distance accumulator.
package hamming_dev_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bits needed to hold a per-sample distance in 0..width.
  function automatic int hd_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Accumulator width: enough for (2^cnt_w - 1) samples of distance width.
  function automatic int sum_width(input int cnt_w, input int width);
    return cnt_w + hd_width(width);
  endfunction

endpackage

// File: rtl/hamming_dev_accum_hd_popcount.sv
// Combinational population count built as a balanced binary adder tree.
module hd_popcount
  import hamming_dev_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  output logic [HD_W-1:0]  count
);

  // Leaves padded to a power of two; heap indexing, root at node[1].
  localparam int unsigned LEAVES = 1 << $clog2(WIDTH);

  // Sum pairs of nodes level by level from the leaves up to the root.
  always_comb begin : tree
    logic [HD_W-1:0] node [2*LEAVES];
    for (int unsigned i = 0; i < 2 * LEAVES; i++) begin
      node[i] = '0;
    end
    for (int unsigned i = 0; i < LEAVES; i++) begin
      if (i < WIDTH) begin
        node[LEAVES + i] = HD_W'(x[i]);
      end
    end
    for (int unsigned k = LEAVES - 1; k >= 1; k--) begin
      node[k] = node[2*k] + node[2*k + 1];
    end
    count = node[1];
  end

endmodule

// File: rtl/hamming_dev_accum.sv
// Accumulates Hamming-distance statistics between golden and approximate
// words over a window of num_samples accepted pairs.
module hamming_dev_accum
  import hamming_dev_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int CNT_W = 16,
  localparam int HD_W  = hd_width(WIDTH),
  localparam int SUM_W = sum_width(CNT_W, WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_hd,
  output logic [HD_W-1:0]  max_hd,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           state, state_next;
  logic [CNT_W-1:0] target, cnt;
  logic             accept, last_accept, start_acc;

  // Stage 1 holds the XOR of the accepted pair, stage 2 its distance.
  logic [WIDTH-1:0] x_q;
  logic             v0, last0;
  logic [HD_W-1:0]  hd_c, hd_q;
  logic             v1, last1;

  assign in_ready    = (state == RUN);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((cnt + 1'b1) == target);
  assign start_acc   = (state == IDLE) && start;

  hd_popcount #(.WIDTH(WIDTH)) u_popcount (
    .x     (x_q),
    .count (hd_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: zero-length windows never leave IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && num_samples != '0) state_next = RUN;
      RUN:     if (last_accept)                state_next = DRAIN;
      DRAIN:   if (v1 && last1)                state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  // Window bookkeeping: latched length and accepted-sample count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
      cnt    <= '0;
    end else if (start_acc) begin
      target <= num_samples;
      cnt    <= '0;
    end else if (accept) begin
      cnt    <= cnt + 1'b1;
    end
  end

  // Two-stage pipeline: capture XOR on acceptance, then register distance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      v0    <= 1'b0;
      last0 <= 1'b0;
      hd_q  <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      v0    <= accept;
      last0 <= last_accept;
      if (accept) x_q <= a ^ b;
      v1    <= v0;
      last1 <= v0 && last0;
      if (v0) hd_q <= hd_c;
    end
  end

  // Accumulators and the done pulse; results hold until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_hd  <= '0;
      max_hd  <= '0;
      err_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        sum_hd  <= '0;
        max_hd  <= '0;
        err_cnt <= '0;
        done    <= (num_samples == '0);
      end else if (v1) begin
        sum_hd <= sum_hd + SUM_W'(hd_q);
        if (hd_q > max_hd) max_hd <= hd_q;
        if (hd_q != '0)    err_cnt <= err_cnt + 1'b1;
        if (last1)         done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_dev_accum.sv
// Directed self-checking bench for hamming_dev_accum (default and CNT_W=4).
module tb_hamming_dev_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Default-parameter instance (WIDTH=32, CNT_W=16 -> HD_W=6, SUM_W=22).
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [21:0] sum_hd;
  logic [5:0]  max_hd;
  logic [15:0] err_cnt;

  // Narrow-counter instance (WIDTH=32, CNT_W=4 -> SUM_W=10).
  logic        start2 = 1'b0;
  logic [3:0]  num2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2;
  logic [31:0] a2 = '0, b2 = '0;
  logic        busy2, done2;
  logic [9:0]  sum2;
  logic [5:0]  max2;
  logic [3:0]  err2;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] va [4];
  logic [31:0] vb [4];

  always #5 clk = ~clk;

  hamming_dev_accum #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .busy(busy), .done(done), .sum_hd(sum_hd), .max_hd(max_hd), .err_cnt(err_cnt)
  );

  hamming_dev_accum #(.WIDTH(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .num_samples(num2),
    .in_valid(valid2), .in_ready(ready2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum_hd(sum2), .max_hd(max2), .err_cnt(err2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_reference();
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000;
    va[2] = 32'h0000_000F; vb[2] = 32'h0000_000C;
    va[3] = 32'h8000_0001; vb[3] = 32'h0000_0000;
  endtask

  // Entered and left on a falling edge.
  task automatic start_window(input int n);
    start = 1'b1;
    num_samples = 16'(n);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
  endtask

  task automatic run_pairs(input int n, input bit gap, input bit hold, input bit poke);
    int lat;
    for (int i = 0; i < n; i++) begin
      check_eq("in_ready_run", in_ready, 1);
      in_valid = 1'b1;
      a = va[i];
      b = vb[i];
      if (poke && i == 1) begin
        start = 1'b1;
        num_samples = 16'd2;
      end
      @(negedge clk);
      start = 1'b0;
      if (gap && i != n - 1) begin
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
      end
    end
    if (hold) begin
      a = 32'hFFFF_FFFF;
      b = 32'h0000_0000;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!done && lat < 8) begin
      if (hold) check_eq("drain_in_ready", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check_eq("done_latency", lat, 2);
    in_valid = 1'b0;
  endtask

  task automatic check_results(input int s, input int m, input int e);
    check_eq("sum_hd", sum_hd, s);
    check_eq("max_hd", max_hd, m);
    check_eq("err_cnt", err_cnt, e);
    check_eq("busy_at_done", busy, 0);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("sum_hd_hold", sum_hd, s);
    check_eq("max_hd_hold", max_hd, m);
    check_eq("err_cnt_hold", err_cnt, e);
  endtask

  initial begin : main
    int k;
    #1;
    check_eq("rst_sum", sum_hd, 0);
    check_eq("rst_max", max_hd, 0);
    check_eq("rst_err", err_cnt, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back reference window, started on the first edge after reset.
    load_reference();
    start_window(4);
    run_pairs(4, 1'b0, 1'b0, 1'b0);
    check_results(36, 32, 3);

    // Same stimulus with a bubble between samples.
    start_window(4);
    run_pairs(4, 1'b1, 1'b0, 1'b0);
    check_results(36, 32, 3);

    // Zero-length window.
    start = 1'b1;
    num_samples = '0;
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_done", done, 1);
    check_eq("zero_busy", busy, 0);
    check_eq("zero_sum", sum_hd, 0);
    check_eq("zero_max", max_hd, 0);
    check_eq("zero_err", err_cnt, 0);
    @(negedge clk);
    check_eq("zero_done_clear", done, 0);
    check_eq("zero_busy_after", busy, 0);

    // Start poked mid-window; in_valid held high through DRAIN.
    start_window(4);
    run_pairs(4, 1'b0, 1'b1, 1'b1);
    check_results(36, 32, 3);

    // Reset after two of four samples, with both pipeline stages loaded.
    start_window(4);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = va[i];
      b = vb[i];
      @(negedge clk);
    end
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0000;
    rst = 1'b1;
    #1;
    check_eq("midrst_sum", sum_hd, 0);
    check_eq("midrst_max", max_hd, 0);
    check_eq("midrst_err", err_cnt, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    va[0] = 32'h0000_00FF;
    vb[0] = 32'h0000_0000;
    start_window(1);
    run_pairs(1, 1'b0, 1'b0, 1'b0);
    check_results(8, 8, 1);

    // Narrow counter: 15 all-ones samples, in_valid left high throughout.
    start2 = 1'b1;
    num2 = 4'd15;
    @(negedge clk);
    start2 = 1'b0;
    valid2 = 1'b1;
    a2 = 32'hFFFF_FFFF;
    b2 = 32'h0000_0000;
    k = 0;
    while (!done2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    valid2 = 1'b0;
    check_eq("small_done_cycles", k, 17);
    check_eq("small_sum", sum2, 480);
    check_eq("small_max", max2, 32);
    check_eq("small_err", err2, 15);
    check_eq("small_busy", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
